multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main sequencer for the multicycle MIPS datapath. Steps each instruction through fetch, decode, execute, memory and write-back states. Drives every datapath mux and write-enable, and produces the 3-bit `alu_op_o` consumed by the ALU control decoder. Handles variable-latency memory through a ready handshake with a timeout, halts on illegal opcodes, and counts retired instructions.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum cycles any memory wait state may wait for `mem_ready_i`; 0 disables the timeout.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode_i` in 6: IR[31:26]; stable from DECODE until the instruction retires.
- `zero_i` in 1: ALU zero flag.
- `mem_ready_i` in 1: memory access completes this cycle.
- `pc_write_o` out 1: PC load enable.
- `pc_source_o` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `i_or_d_o` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read_o`, `mem_write_o` out 1: memory strobes, held until ready.
- `ir_write_o` out 1: IR load enable.
- `reg_write_o`, `reg_dst_o`, `mem_to_reg_o` out 1: register-file controls; `reg_dst_o` 1 = rd.
- `alu_src_a_o` out 1: 0 = PC, 1 = A.
- `alu_src_b_o` out 2: 00 B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2.
- `alu_op_o` out 3: 111 R-type (funct decides), 100 add, 000 LUI, 001 subtract.
- `state_o` out 4: current state encoding.
- `illegal_op_o` out 1: sticky; unknown opcode caused a halt.
- `bus_error_o` out 1: sticky; memory timeout caused a halt.
- `instr_count_o` out 32: count of retired instructions.

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5.
  - EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11, HALT=12.
  - Codes 13-15 go to HALT with both sticky flags unchanged.
- Outputs are 0 unless listed for the current state.
- FETCH:
  - Outputs: `mem_read_o`=1, `alu_src_b_o`=01, `alu_op_o`=100.
  - When `mem_ready_i`=1: `ir_write_o`=1 and `pc_write_o`=1 (same cycle, Mealy), then go to DECODE. Otherwise stay.
- DECODE:
  - Outputs: `alu_src_b_o`=11, `alu_op_o`=100 (branch target into ALUOut).
  - Dispatch on `opcode_i`: 000000 → EXEC_R; 100011 (LW) or 101011 (SW) → MEM_ADDR; 001000 (ADDI) or 001111 (LUI) → EXEC_I; 000100 (BEQ) → BRANCH; 000010 (J) → JUMP.
  - Any other opcode → HALT and set `illegal_op_o`.
- MEM_ADDR:
  - Outputs: `alu_src_a_o`=1, `alu_src_b_o`=10, `alu_op_o`=100.
  - Next: MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: `mem_read_o`=1, `i_or_d_o`=1; go to MEM_WB on ready.
- MEM_WB: `reg_write_o`=1, `mem_to_reg_o`=1; retire; go to FETCH.
- MEM_WRITE: `mem_write_o`=1, `i_or_d_o`=1; on ready, retire and go to FETCH.
- EXEC_R: `alu_src_a_o`=1, `alu_op_o`=111; go to R_WB.
- R_WB: `reg_write_o`=1, `reg_dst_o`=1; retire; go to FETCH.
- EXEC_I: `alu_src_a_o`=1, `alu_src_b_o`=10; `alu_op_o`=100 for ADDI, 000 for LUI; go to I_WB.
- I_WB: `reg_write_o`=1, `reg_dst_o`=0; retire; go to FETCH.
- BRANCH: `alu_src_a_o`=1, `alu_op_o`=001, `pc_source_o`=01, `pc_write_o`=`zero_i`; retire; go to FETCH.
- JUMP: `pc_source_o`=10, `pc_write_o`=1; retire; go to FETCH.
- HALT: all controls 0. Absorbing; only reset exits.
- Retire: `instr_count_o` increments by 1 in the retire cycle and wraps from 0xFFFFFFFF to 0. Halted instructions never retire.
- Wait counter (8 bits):
  - Cleared on every state transition.
  - Increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with `mem_ready_i`=0.
  - If `TIMEOUT_CYCLES`≠0 and the counter equals `TIMEOUT_CYCLES`-1 while `mem_ready_i`=0: go to HALT and set `bus_error_o`.
  - If `mem_ready_i`=1 in that same cycle, the access completes normally; ready wins over the timeout.

## Timing
- Reset:
  - Asserting `reset` immediately forces state FETCH, wait counter 0, `instr_count_o`=0, and both sticky flags 0.
  - All control outputs are gated to 0 while `reset`=0, including mid-access strobes.
  - First active FETCH cycle is the first rising edge after deassertion.
- Latencies with zero-wait memory (`mem_ready_i` tied 1):
  - R-type, ADDI, LUI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ and J: 3 cycles.
- Each wait cycle adds 1 to the instruction's latency.
- Memory strobes remain asserted, and the address select stays stable, until the cycle `mem_ready_i` is sampled high.
- `mem_ready_i` outside the wait states is ignored.
- `state_o`, both flags and `instr_count_o` are registered. Other outputs are combinational from state, with `opcode_i`, `zero_i` and `mem_ready_i` as listed.

## Test plan
- Reset then ready=1, ADD opcode 000000: states 0,1,6,7,0. `alu_op_o`=111 in EXEC_R. `reg_write_o`=1 and `reg_dst_o`=1 in R_WB. `instr_count_o`=1 after 4 cycles.
- LW with ready held low 3 cycles in MEM_READ: `mem_read_o`=1 and `i_or_d_o`=1 for 4 cycles, then MEM_WB with `mem_to_reg_o`=1. Total 8 cycles.
- BEQ with `zero_i`=1, then BEQ with `zero_i`=0: `pc_write_o`=1 and 0 respectively in BRANCH. `alu_op_o`=001 both times. Count +2.
- ADDI, then LUI: `alu_op_o`=100, then 000, in EXEC_I. `alu_src_b_o`=10 both times.
- Opcode 111111: HALT (`state_o`=12), `illegal_op_o`=1, count unchanged. State held until reset pulse clears it.
- `TIMEOUT_CYCLES`=4, ready never high in FETCH: HALT after exactly 4 FETCH cycles, `bus_error_o`=1. Repeat with ready=1 on the 4th cycle: DECODE entered, no error.

Source files
------------

// File: rtl/multicycle_control.sv
// Main sequencer for the multicycle MIPS datapath: steps each instruction through
// fetch/decode/execute/memory/write-back and drives every datapath control.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic [1:0]  pc_source_o,
    output logic        i_or_d_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_op_o,
    output logic [3:0]  state_o,
    output logic        illegal_op_o,
    output logic        bus_error_o,
    output logic [31:0] instr_count_o
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        R_WB      = 4'd7,
        EXEC_I    = 4'd8,
        I_WB      = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11,
        HALT      = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam bit         TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  wait_cnt;
    logic        mem_wait;
    logic        timed_out;
    logic        retire;
    logic        set_illegal;
    logic        set_bus_err;

    logic        pc_write;
    logic [1:0]  pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;

    assign timed_out = TIMEOUT_EN && !mem_ready_i && (wait_cnt == TIMEOUT_LAST);

    always_comb begin
        next_state  = state;
        mem_wait    = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        pc_write    = 1'b0;
        pc_source   = 2'b00;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 3'b000;

        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b100;
                if (mem_ready_i) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = DECODE;
                end else begin
                    mem_wait = 1'b1;
                    if (timed_out) begin
                        next_state  = HALT;
                        set_bus_err = 1'b1;
                    end
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 3'b100;
                case (opcode_i)
                    OP_R:           next_state = EXEC_R;
                    OP_LW, OP_SW:   next_state = MEM_ADDR;
                    OP_ADDI, OP_LUI: next_state = EXEC_I;
                    OP_BEQ:         next_state = BRANCH;
                    OP_J:           next_state = JUMP;
                    default: begin
                        next_state  = HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = 3'b100;
                next_state = (opcode_i == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready_i) begin
                    next_state = MEM_WB;
                end else begin
                    mem_wait = 1'b1;
                    if (timed_out) begin
                        next_state  = HALT;
                        set_bus_err = 1'b1;
                    end
                end
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready_i) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end else begin
                    mem_wait = 1'b1;
                    if (timed_out) begin
                        next_state  = HALT;
                        set_bus_err = 1'b1;
                    end
                end
            end
            EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b111;
                next_state = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = (opcode_i == OP_LUI) ? 3'b000 : 3'b100;
                next_state = I_WB;
            end
            I_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b001;
                pc_source  = 2'b01;
                pc_write   = zero_i;
                retire     = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            HALT:    next_state = HALT;
            default: next_state = HALT;
        endcase
    end

    // The wait counter restarts on any state change so each memory access gets a full budget.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= FETCH;
            wait_cnt      <= 8'd0;
            instr_count_o <= 32'd0;
            illegal_op_o  <= 1'b0;
            bus_error_o   <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= 8'd0;
            else if (mem_wait)
                wait_cnt <= wait_cnt + 8'd1;
            if (retire)
                instr_count_o <= instr_count_o + 32'd1;
            if (set_illegal)
                illegal_op_o <= 1'b1;
            if (set_bus_err)
                bus_error_o <= 1'b1;
        end
    end

    // Controls are forced low while reset is held, even if a strobe was mid-access.
    assign state_o      = state;
    assign pc_write_o   = reset & pc_write;
    assign pc_source_o  = reset ? pc_source : 2'b00;
    assign i_or_d_o     = reset & i_or_d;
    assign mem_read_o   = reset & mem_read;
    assign mem_write_o  = reset & mem_write;
    assign ir_write_o   = reset & ir_write;
    assign reg_write_o  = reset & reg_write;
    assign reg_dst_o    = reset & reg_dst;
    assign mem_to_reg_o = reset & mem_to_reg;
    assign alu_src_a_o  = reset & alu_src_a;
    assign alu_src_b_o  = reset ? alu_src_b : 2'b00;
    assign alu_op_o     = reset ? alu_op : 3'b000;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, memory waits,
// illegal opcode halt and the memory timeout boundary with TIMEOUT_CYCLES=4.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        pc_write_o;
    logic [1:0]  pc_source_o;
    logic        i_or_d_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        ir_write_o;
    logic        reg_write_o;
    logic        reg_dst_o;
    logic        mem_to_reg_o;
    logic        alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic [2:0]  alu_op_o;
    logic [3:0]  state_o;
    logic        illegal_op_o;
    logic        bus_error_o;
    logic [31:0] instr_count_o;

    int totalChecks = 0;
    int passedChecks = 0;

    multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode_i     (opcode_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .pc_write_o   (pc_write_o),
        .pc_source_o  (pc_source_o),
        .i_or_d_o     (i_or_d_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .ir_write_o   (ir_write_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .state_o      (state_o),
        .illegal_op_o (illegal_op_o),
        .bus_error_o  (bus_error_o),
        .instr_count_o(instr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        else
            passedChecks++;
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked 1 unit later.
    task automatic applyStimulus(input logic [5:0] op, input logic z, input logic rdy);
        opcode_i    = op;
        zero_i      = z;
        mem_ready_i = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        #1;
        checkOutput("rst_state", 32'(state_o), 32'd0);
        checkOutput("rst_count", instr_count_o, 32'd0);
        checkOutput("rst_illegal", 32'(illegal_op_o), 32'd0);
        checkOutput("rst_buserr", 32'(bus_error_o), 32'd0);
        checkOutput("rst_memread_gated", 32'(mem_read_o), 32'd0);
        reset = 1'b1;
    endtask

    // Runs FETCH and DECODE with zero-wait memory, leaving the DUT one edge past DECODE.
    task automatic fetchDecode(input logic [5:0] op, input logic z);
        applyStimulus(op, z, 1'b1);
        checkOutput("fetch_state", 32'(state_o), 32'd0);
        tick();
        checkOutput("decode_state", 32'(state_o), 32'd1);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(6'b000000, 1'b0, 1'b1);
        checkOutput("por_state", 32'(state_o), 32'd0);
        checkOutput("por_memread_gated", 32'(mem_read_o), 32'd0);
        checkOutput("por_irwrite_gated", 32'(ir_write_o), 32'd0);
        checkOutput("por_count", instr_count_o, 32'd0);
        tick();
        reset = 1'b1;
        #1;

        // ADD: 0,1,6,7,0
        checkOutput("add_f_memread", 32'(mem_read_o), 32'd1);
        checkOutput("add_f_irwrite", 32'(ir_write_o), 32'd1);
        checkOutput("add_f_pcwrite", 32'(pc_write_o), 32'd1);
        checkOutput("add_f_srcb", 32'(alu_src_b_o), 32'd1);
        checkOutput("add_f_aluop", 32'(alu_op_o), 32'd4);
        tick();
        checkOutput("add_d_state", 32'(state_o), 32'd1);
        checkOutput("add_d_srcb", 32'(alu_src_b_o), 32'd3);
        checkOutput("add_d_aluop", 32'(alu_op_o), 32'd4);
        tick();
        checkOutput("add_x_state", 32'(state_o), 32'd6);
        checkOutput("add_x_aluop", 32'(alu_op_o), 32'd7);
        checkOutput("add_x_srca", 32'(alu_src_a_o), 32'd1);
        tick();
        checkOutput("add_wb_state", 32'(state_o), 32'd7);
        checkOutput("add_wb_regwrite", 32'(reg_write_o), 32'd1);
        checkOutput("add_wb_regdst", 32'(reg_dst_o), 32'd1);
        tick();
        checkOutput("add_done_state", 32'(state_o), 32'd0);
        checkOutput("add_count", instr_count_o, 32'd1);

        // LW with three wait cycles in MEM_READ; 4th cycle ready hits the timeout boundary
        fetchDecode(6'b100011, 1'b0);
        checkOutput("lw_addr_state", 32'(state_o), 32'd2);
        checkOutput("lw_addr_srca", 32'(alu_src_a_o), 32'd1);
        checkOutput("lw_addr_srcb", 32'(alu_src_b_o), 32'd2);
        applyStimulus(6'b100011, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) applyStimulus(6'b100011, 1'b0, 1'b1);
            checkOutput("lw_rd_state", 32'(state_o), 32'd3);
            checkOutput("lw_rd_memread", 32'(mem_read_o), 32'd1);
            checkOutput("lw_rd_iord", 32'(i_or_d_o), 32'd1);
            tick();
        end
        checkOutput("lw_wb_state", 32'(state_o), 32'd4);
        checkOutput("lw_wb_memtoreg", 32'(mem_to_reg_o), 32'd1);
        checkOutput("lw_wb_regwrite", 32'(reg_write_o), 32'd1);
        checkOutput("lw_wb_buserr", 32'(bus_error_o), 32'd0);
        tick();
        checkOutput("lw_count", instr_count_o, 32'd2);

        // BEQ taken then not taken
        fetchDecode(6'b000100, 1'b1);
        checkOutput("beq1_state", 32'(state_o), 32'd10);
        checkOutput("beq1_pcwrite", 32'(pc_write_o), 32'd1);
        checkOutput("beq1_aluop", 32'(alu_op_o), 32'd1);
        checkOutput("beq1_pcsrc", 32'(pc_source_o), 32'd1);
        tick();
        fetchDecode(6'b000100, 1'b0);
        checkOutput("beq0_pcwrite", 32'(pc_write_o), 32'd0);
        checkOutput("beq0_aluop", 32'(alu_op_o), 32'd1);
        tick();
        checkOutput("beq_count", instr_count_o, 32'd4);

        // ADDI then LUI
        fetchDecode(6'b001000, 1'b0);
        checkOutput("addi_state", 32'(state_o), 32'd8);
        checkOutput("addi_aluop", 32'(alu_op_o), 32'd4);
        checkOutput("addi_srcb", 32'(alu_src_b_o), 32'd2);
        tick();
        checkOutput("addi_wb_state", 32'(state_o), 32'd9);
        checkOutput("addi_wb_regwrite", 32'(reg_write_o), 32'd1);
        checkOutput("addi_wb_regdst", 32'(reg_dst_o), 32'd0);
        tick();
        fetchDecode(6'b001111, 1'b0);
        checkOutput("lui_aluop", 32'(alu_op_o), 32'd0);
        checkOutput("lui_srcb", 32'(alu_src_b_o), 32'd2);
        tick();
        tick();
        checkOutput("lui_count", instr_count_o, 32'd6);

        // SW and J
        fetchDecode(6'b101011, 1'b0);
        tick();
        checkOutput("sw_state", 32'(state_o), 32'd5);
        checkOutput("sw_memwrite", 32'(mem_write_o), 32'd1);
        checkOutput("sw_iord", 32'(i_or_d_o), 32'd1);
        tick();
        checkOutput("sw_count", instr_count_o, 32'd7);
        fetchDecode(6'b000010, 1'b0);
        checkOutput("j_state", 32'(state_o), 32'd11);
        checkOutput("j_pcsrc", 32'(pc_source_o), 32'd2);
        checkOutput("j_pcwrite", 32'(pc_write_o), 32'd1);
        tick();
        checkOutput("j_count", instr_count_o, 32'd8);

        // Illegal opcode halts and sticks
        fetchDecode(6'b111111, 1'b0);
        checkOutput("ill_state", 32'(state_o), 32'd12);
        checkOutput("ill_flag", 32'(illegal_op_o), 32'd1);
        checkOutput("ill_count", instr_count_o, 32'd8);
        tick();
        tick();
        checkOutput("ill_held_state", 32'(state_o), 32'd12);
        checkOutput("ill_held_memread", 32'(mem_read_o), 32'd0);
        pulseReset();

        // Timeout: ready never high, HALT after exactly 4 FETCH cycles
        applyStimulus(6'b000000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("to_fetch4_state", 32'(state_o), 32'd0);
        tick();
        checkOutput("to_halt_state", 32'(state_o), 32'd12);
        checkOutput("to_buserr", 32'(bus_error_o), 32'd1);
        checkOutput("to_illegal", 32'(illegal_op_o), 32'd0);
        pulseReset();

        // Ready on the 4th FETCH cycle wins over the timeout
        applyStimulus(6'b000000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        applyStimulus(6'b000000, 1'b0, 1'b1);
        checkOutput("rdy4_irwrite", 32'(ir_write_o), 32'd1);
        tick();
        checkOutput("rdy4_state", 32'(state_o), 32'd1);
        checkOutput("rdy4_buserr", 32'(bus_error_o), 32'd0);

        $display("[TB] %0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
